// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared types and default sizes for the memory arbiter
package soc_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_MEM_LAT = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

endpackage

// File: rtl/arb_sel.sv
// rtl/arb_sel.sv - combinational grant pick between IFU and LSU
// ARB_RR_EN selects alternation under contention; default is fixed LSU priority.
module arb_sel
  import soc_pkg::*;
(
  input  logic   ifu_valid,
  input  logic   lsu_valid,
  input  owner_t last_owner,
  output owner_t grant_owner,
  output logic   grant_valid
);

`ifdef ARB_RR_EN
  always_comb begin
    grant_valid = ifu_valid | lsu_valid;
    grant_owner = lsu_valid ? OWN_LSU : OWN_IFU;
    if (ifu_valid && lsu_valid) begin
      grant_owner = (last_owner == OWN_LSU) ? OWN_IFU : OWN_LSU;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = last_owner;

  always_comb begin
    grant_valid = ifu_valid | lsu_valid;
    grant_owner = lsu_valid ? OWN_LSU : OWN_IFU;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one fixed-latency memory between IFU and LSU
// Build with ARB_RR_EN for round-robin grants under contention.
module mem_arbiter
  import soc_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [31:0]         ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_we,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t                r_state;
  state_t                w_state_nxt;
  owner_t                r_owner;
  owner_t                r_last_owner;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_we;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wmask;
  logic [3:0]            r_cnt;
  logic [31:0]           r_ifu_rdata;
  logic [DATA_W-1:0]     r_lsu_rdata;
  owner_t                w_grant_owner;
  logic                  w_grant_valid;
  logic                  w_hs;

  arb_sel u_arb_sel (
    .ifu_valid   (ifu_req_valid),
    .lsu_valid   (lsu_req_valid),
    .last_owner  (r_last_owner),
    .grant_owner (w_grant_owner),
    .grant_valid (w_grant_valid)
  );

  // Ready is masked by rst so nothing is accepted while reset is held.
  assign w_hs = (r_state == IDLE) && w_grant_valid && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (r_cnt == 4'd0) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready = w_hs && (w_grant_owner == OWN_IFU);
    lsu_req_ready = w_hs && (w_grant_owner == OWN_LSU);
    mem_en        = (r_state == ISSUE);
    mem_we        = mem_en && r_we;
    mem_addr      = mem_en ? r_addr  : '0;
    mem_wdata     = mem_en ? r_wdata : '0;
    mem_wmask     = mem_en ? r_wmask : '0;
    ifu_rsp_valid = (r_state == RESP) && (r_owner == OWN_IFU);
    lsu_rsp_valid = (r_state == RESP) && (r_owner == OWN_LSU);
    ifu_rdata     = r_ifu_rdata;
    lsu_rdata     = r_lsu_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= OWN_IFU;
      r_last_owner <= OWN_IFU;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_cnt        <= 4'd0;
      r_ifu_rdata  <= '0;
      r_lsu_rdata  <= '0;
    end else begin
      if (w_hs) begin
        r_owner      <= w_grant_owner;
        r_last_owner <= w_grant_owner;
        if (w_grant_owner == OWN_LSU) begin
          r_addr  <= lsu_addr;
          r_we    <= lsu_we;
          r_wdata <= lsu_wdata;
          r_wmask <= lsu_wmask;
        end else begin
          r_addr  <= ifu_addr;
          r_we    <= 1'b0;
          r_wdata <= '0;
          r_wmask <= '0;
        end
      end
      if (r_state == ISSUE) begin
        r_cnt <= 4'(MEM_LAT - 1);
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if ((r_state == WAIT) && (r_cnt == 4'd0)) begin
        if (r_owner == OWN_IFU) r_ifu_rdata <= mem_rdata[31:0];
        else                    r_lsu_rdata <= r_we ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (ARB_RR_EN aware)
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu_req_valid = 1'b0;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr = '0;
  logic          ifu_rsp_valid;
  logic [31:0]   ifu_rdata;
  logic          lsu_req_valid = 1'b0;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr = '0;
  logic          lsu_we = 1'b0;
  logic [DW-1:0] lsu_wdata = '0;
  logic [7:0]    lsu_wmask = '0;
  logic          lsu_rsp_valid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wmask;
  logic [DW-1:0] mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_we(lsu_we), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic own; logic [63:0] data; int cyc; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [63:0] wdata; logic [7:0] wmask; int cyc; } mreq_t;

  rsp_t  rsp_q[$];
  mreq_t mem_q[$];
  logic  grant_log[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    idle_from = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: 512 words indexed by addr[10:2], read data MEM_LAT cycles after mem_en.
  logic [63:0] mem [512];
  logic [63:0] pipe [LAT];
  logic        loaded = 1'b0;

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] w, input logic [7:0] m);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 512; i++) mem[i] <= 64'h0;
      mem[0]   <= 64'h1234_5678_0000_0513;
      mem[1]   <= 64'hFFFF_EEEE_00A0_0593;
      mem[2]   <= 64'h0BAD_F00D_00B5_0633;
      mem[3]   <= 64'h0000_0000_0000_0073;
      mem[4]   <= 64'h0000_0000_DEAD_0013;
      mem[66]  <= 64'h0102_0304_0506_0708;
      mem[128] <= 64'hCAFE_BABE_0123_4567;
      mem[130] <= 64'h8899_AABB_CCDD_EEFF;
      loaded   <= 1'b1;
    end else begin
      pipe[0] <= mem_en ? mem[mem_addr[10:2]] : 64'hBADB_AD00_BADB_AD00;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      if (mem_en && mem_we) mem[mem_addr[10:2]] <= merge(mem[mem_addr[10:2]], mem_wdata, mem_wmask);
    end
  end
  assign mem_rdata = pipe[LAT-1];

  rsp_t  mon_r;
  mreq_t mon_m;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifu_req_ready || lsu_req_ready) begin
        chk("ready_exclusive", 64'(ifu_req_ready & lsu_req_ready), 64'h0);
        chk("ready_too_early", 64'(cyc < idle_from), 64'h0);
        if ((ifu_req_ready && ifu_req_valid) || (lsu_req_ready && lsu_req_valid))
          idle_from = cyc + 3 + LAT;
      end
      if (mem_en) begin
        if (mem_q.size() == 0) chk("unexpected_mem_en", 64'h1, 64'h0);
        else begin
          mon_m = mem_q.pop_front();
          chk("mem_en_cycle", 64'(cyc), 64'(mon_m.cyc));
          chk("mem_we", 64'(mem_we), 64'(mon_m.we));
          chk("mem_addr", 64'(mem_addr), 64'(mon_m.addr));
          chk("mem_wdata", mem_wdata, mon_m.wdata);
          chk("mem_wmask", 64'(mem_wmask), 64'(mon_m.wmask));
        end
      end else begin
        chk("mem_idle_zero", 64'(|{mem_we, mem_addr, mem_wdata, mem_wmask}), 64'h0);
      end
      if (ifu_rsp_valid || lsu_rsp_valid) begin
        chk("rsp_exclusive", 64'(ifu_rsp_valid & lsu_rsp_valid), 64'h0);
        if (rsp_q.size() == 0) chk("unexpected_rsp", 64'h1, 64'h0);
        else begin
          mon_r = rsp_q.pop_front();
          chk("rsp_owner", 64'(lsu_rsp_valid), 64'(mon_r.own));
          chk("rsp_cycle", 64'(cyc), 64'(mon_r.cyc));
          chk("rsp_data", lsu_rsp_valid ? lsu_rdata : {32'h0, ifu_rdata}, mon_r.data);
        end
      end
    end
  end

  task automatic ifu_req(input logic [31:0] a, input logic [31:0] exp, output int t);
    rsp_t  r;
    mreq_t m;
    ifu_req_valid = 1'b1;
    ifu_addr      = a;
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifu_req_ready) begin t = cyc; break; end
    end
    if (t < 0) chk("ifu_handshake_timeout", 64'h1, 64'h0);
    else begin
      m.we = 1'b0; m.addr = a; m.wdata = '0; m.wmask = '0; m.cyc = t + 1;
      mem_q.push_back(m);
      r.own = 1'b0; r.data = {32'h0, exp}; r.cyc = t + 2 + LAT;
      rsp_q.push_back(r);
      grant_log.push_back(1'b0);
    end
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
  endtask

  task automatic lsu_req(input logic we, input logic [31:0] a, input logic [63:0] wd,
                         input logic [7:0] wm, input logic [63:0] exp, output int t);
    rsp_t  r;
    mreq_t m;
    lsu_req_valid = 1'b1;
    lsu_addr = a; lsu_we = we; lsu_wdata = wd; lsu_wmask = wm;
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lsu_req_ready) begin t = cyc; break; end
    end
    if (t < 0) chk("lsu_handshake_timeout", 64'h1, 64'h0);
    else begin
      m.we = we; m.addr = a; m.wdata = wd; m.wmask = wm; m.cyc = t + 1;
      mem_q.push_back(m);
      r.own = 1'b1; r.data = exp; r.cyc = t + 2 + LAT;
      rsp_q.push_back(r);
      grant_log.push_back(1'b1);
    end
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    lsu_addr = '0; lsu_we = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, ti, tl, td;
    logic [3:0] exp_seq;

    repeat (3) @(negedge clk);
    chk("reset_ctrl_outputs", 64'({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                                    mem_en, mem_we, |mem_addr, |mem_wdata, |mem_wmask}), 64'h0);
    chk("reset_ifu_rdata", 64'(ifu_rdata), 64'h0);
    chk("reset_lsu_rdata", lsu_rdata, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    ifu_req(32'h8000_0000, 32'h0000_0513, t1);
    ifu_req(32'h8000_0004, 32'h00A0_0593, t1);
    ifu_req(32'h8000_0008, 32'h00B5_0633, t2);
    chk("b2b_ifu_spacing", 64'(t2 - t1), 64'(3 + LAT));

    lsu_req(1'b1, 32'h8000_0100, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, td);
    lsu_req(1'b0, 32'h8000_0100, 64'h0, 8'h00, 64'h1122_3344_5566_7788, td);
    lsu_req(1'b1, 32'h8000_0108, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'h0, td);
    lsu_req(1'b0, 32'h8000_0108, 64'h0, 8'h00, 64'h0102_0304_AAAA_AAAA, td);

    ifu_req(32'h8000_000C, 32'h0000_0073, td);
    fork
      lsu_req(1'b0, 32'h8000_0200, 64'h0, 8'h00, 64'hCAFE_BABE_0123_4567, tl);
      ifu_req(32'h8000_0000, 32'h0000_0513, ti);
    join
    chk("contention_ifu_after_lsu", 64'(ti - tl), 64'(3 + LAT));

    grant_log.delete();
    fork
      begin
        lsu_req(1'b0, 32'h8000_0200, 64'h0, 8'h00, 64'hCAFE_BABE_0123_4567, td);
        lsu_req(1'b0, 32'h8000_0208, 64'h0, 8'h00, 64'h8899_AABB_CCDD_EEFF, td);
      end
      begin
        ifu_req(32'h8000_0004, 32'h00A0_0593, ti);
        ifu_req(32'h8000_0008, 32'h00B5_0633, ti);
      end
    join
`ifdef ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b1100;
`endif
    chk("sustained_grant_count", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk($sformatf("sustained_grant_%0d", k), 64'(grant_log[k]), 64'(exp_seq[3-k]));

    repeat (3) @(posedge clk);
    #1;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0010;
    t1 = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifu_req_ready) begin t1 = cyc; break; end
    end
    if (t1 < 0) chk("rst_test_handshake_timeout", 64'h1, 64'h0);
    else begin
      mreq_t m;
      m.we = 1'b0; m.addr = 32'h8000_0010; m.wdata = '0; m.wmask = '0; m.cyc = t1 + 1;
      mem_q.push_back(m);
    end
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle_from = 0;
    #1;
    chk("rst_in_wait_outputs", 64'({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                                     mem_en, mem_we, |mem_addr, |mem_wdata, |mem_wmask}), 64'h0);
    chk("rst_in_wait_rdata", 64'(|{ifu_rdata, lsu_rdata}), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    ifu_req(32'h8000_0004, 32'h00A0_0593, td);

    lsu_req(1'b0, 32'h8000_0200, 64'h0, 8'h00, 64'hCAFE_BABE_0123_4567, td);
    repeat (LAT + 4) @(negedge clk);
    chk("ifu_rdata_held", 64'(ifu_rdata), 64'h0000_0000_00A0_0593);
    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);
    chk("mem_queue_drained", 64'(mem_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory between two requesters: instruction fetch (IFU, read-only) and load/store (LSU, read/write).
- Sits between the core and the memory model in soc.
- Replaces the direct combinational fetch path with valid/ready requests and fixed-latency memory timing.
- One transaction in flight at a time; responses are routed back to the owner.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 64, data width of LSU and memory. IFU uses the low 32 bits.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata. Legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_rsp_valid  out  1  one-cycle pulse: ifu_rdata valid.
- ifu_rdata  out  32  fetched instruction.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  access address.
- lsu_we  in  1  1 = write, 0 = read.
- lsu_wdata  in  DATA_W  write data.
- lsu_wmask  in  DATA_W/8  byte write enables.
- lsu_rsp_valid  out  1  one-cycle pulse: read data valid or write done.
- lsu_rdata  out  DATA_W  load data (0 for writes).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  DATA_W/8  memory byte mask.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- Reset:
  - rst asserted at any time forces state IDLE and discards any in-flight transaction (no response issued).
  - All outputs reset to 0. Round-robin pointer last_owner resets to IFU.
- States:
  - IDLE: if any req_valid, grant one requester. Its req_ready goes high combinationally in the same cycle; the other requester's ready stays 0. Handshake = valid & ready. Latch addr, we, wdata, wmask and owner; go to ISSUE. With no request, stay in IDLE.
  - ISSUE: drive mem_en=1 for exactly one cycle with the latched fields. Load cnt=MEM_LAT-1 and go to WAIT.
  - WAIT: hold while cnt!=0, decrementing each cycle. When cnt==0, capture mem_rdata into the owner's rdata register and go to RESP.
  - RESP: pulse the owner's rsp_valid for one cycle, then go to IDLE.
- Ready is asserted only in IDLE; both readys are 0 in ISSUE, WAIT and RESP.
- Timing:
  - Handshake at cycle T gives mem_en at T+1, mem_rdata sampled at T+1+MEM_LAT, rsp_valid at T+2+MEM_LAT.
  - Earliest next handshake is T+3+MEM_LAT.
- mem_we, mem_addr, mem_wdata and mem_wmask are driven from the latched fields in ISSUE and are 0 otherwise. An IFU owner always gives mem_we=0.
- Writes:
  - lsu_rsp_valid still pulses as an ack.
  - lsu_rdata is set to 0.
- ifu_rdata = mem_rdata[31:0].
- rdata registers hold their value until the next response for that requester.
- There is no response backpressure; requesters must accept rsp_valid when it pulses.
- If req_valid drops before the handshake, nothing happens and no state is consumed.
- Arbitration (baseline): fixed priority, LSU over IFU, so a pending load/store is never starved by fetch.
- On every grant, last_owner is updated to the granted requester.

Optional Feature:
- ARB_RR_EN defined: when both requesters are valid in IDLE, grant the one not equal to last_owner, giving strict alternation under contention. A single valid requester is always granted.
- ARB_RR_EN undefined: fixed LSU priority as described; last_owner still updates but does not affect grants.

Decomposition:
- Shared package soc_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - owner enum {OWN_IFU, OWN_LSU}.
  - Default ADDR_W, DATA_W and MEM_LAT constants.
- One sub-module, arb_sel: combinational grant pick.
  - Inputs: ifu_valid, lsu_valid, last_owner.
  - Output: grant owner and grant-valid.
  - Contains the ARB_RR_EN variant.

Test Plan:
- MEM_LAT=2, IFU only: ifu_addr=0x8000_0000 at T with mem_rdata=0x0000_0513 → mem_en at T+1, ifu_rsp_valid at T+4, ifu_rdata=0x0000_0513, ifu_req_ready low during T+1..T+4.
- LSU write: lsu_we=1, addr=0x8000_0100, wdata=0x1122_3344_5566_7788, wmask=0xFF → mem_en=mem_we=1 at T+1 with those values; lsu_rsp_valid at T+4, lsu_rdata=0.
- Both valid at T, fixed priority → LSU granted; IFU granted at the next IDLE (T+5 with MEM_LAT=2); IFU never gets ready at T.
- ARB_RR_EN, both held valid continuously → grants alternate LSU, IFU, LSU, IFU; no requester gets two consecutive grants.
- rst pulsed during WAIT → all outputs 0 within the same cycle, no rsp_valid; after release, a new IFU request completes normally.
- MEM_LAT=1 back-to-back IFU requests → handshakes exactly 4 cycles apart; each response matches its own address's data.
